// File: rtl/uart_tx_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_engine : 8-bit UART frame serialiser with 4-phase req/ack and    |
// |                  synchronised frame config (parity, stop bits).          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module uart_tx_engine #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk26m,
   input  logic       rst26m_n,
   input  logic       tx_bps_clk,
   input  logic       tx_req,
   input  logic [7:0] tx_data,
   input  logic       check_en,
   input  logic       parity,
   input  logic       two_stop,
   output logic       tx_out,
   output logic       tx_bps_en,
   output logic       tx_ack,
   output logic       tx_busy
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_ACK    = 3'd5
   } state_t;

   logic [SYNC_STAGES-1:0] r_req_sync;
   logic [SYNC_STAGES-1:0] r_ce_sync;
   logic [SYNC_STAGES-1:0] r_par_sync;
   logic [SYNC_STAGES-1:0] r_two_sync;

   logic w_req;
   logic w_ce;
   logic w_par;
   logic w_two;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_shift;
   logic [7:0] w_shift_nxt;
   logic [2:0] r_cnt;
   logic [2:0] w_cnt_nxt;
   logic       r_stop_cnt;
   logic       w_stop_cnt_nxt;
   logic       r_cfg_ce;
   logic       w_cfg_ce_nxt;
   logic       r_cfg_odd;
   logic       w_cfg_odd_nxt;
   logic       r_cfg_two;
   logic       w_cfg_two_nxt;
   logic       r_tx_out;
   logic       w_tx_out_nxt;
   logic       r_bps_en;
   logic       w_bps_en_nxt;
   logic       r_ack;
   logic       w_ack_nxt;
   logic       w_par_bit;

   always_ff @(posedge clk26m or negedge rst26m_n) begin
      if (!rst26m_n) begin
         r_req_sync <= '0;
         r_ce_sync  <= '0;
         r_par_sync <= '0;
         r_two_sync <= '0;
      end else begin
         r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], tx_req};
         r_ce_sync  <= {r_ce_sync[SYNC_STAGES-2:0],  check_en};
         r_par_sync <= {r_par_sync[SYNC_STAGES-2:0], parity};
         r_two_sync <= {r_two_sync[SYNC_STAGES-2:0], two_stop};
      end
   end

   assign w_req = r_req_sync[SYNC_STAGES-1];
   assign w_ce  = r_ce_sync[SYNC_STAGES-1];
   assign w_par = r_par_sync[SYNC_STAGES-1];
   assign w_two = r_two_sync[SYNC_STAGES-1];

   // The shifter rotates, so its XOR reduction always equals that of the latched byte.
   assign w_par_bit = r_cfg_odd ? ~(^r_shift) : (^r_shift);

   always_ff @(posedge clk26m or negedge rst26m_n) begin
      if (!rst26m_n) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_cnt      <= '0;
         r_stop_cnt <= 1'b0;
         r_cfg_ce   <= 1'b0;
         r_cfg_odd  <= 1'b0;
         r_cfg_two  <= 1'b0;
         r_tx_out   <= 1'b1;
         r_bps_en   <= 1'b0;
         r_ack      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_cnt      <= w_cnt_nxt;
         r_stop_cnt <= w_stop_cnt_nxt;
         r_cfg_ce   <= w_cfg_ce_nxt;
         r_cfg_odd  <= w_cfg_odd_nxt;
         r_cfg_two  <= w_cfg_two_nxt;
         r_tx_out   <= w_tx_out_nxt;
         r_bps_en   <= w_bps_en_nxt;
         r_ack      <= w_ack_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_cnt_nxt      = r_cnt;
      w_stop_cnt_nxt = r_stop_cnt;
      w_cfg_ce_nxt   = r_cfg_ce;
      w_cfg_odd_nxt  = r_cfg_odd;
      w_cfg_two_nxt  = r_cfg_two;
      w_tx_out_nxt   = r_tx_out;
      w_bps_en_nxt   = r_bps_en;
      w_ack_nxt      = r_ack;
      case (r_state)
         ST_IDLE: begin
            w_tx_out_nxt = 1'b1;
            w_bps_en_nxt = 1'b0;
            w_ack_nxt    = 1'b0;
            if (w_req && !r_ack) begin
               w_shift_nxt    = tx_data;
               w_cfg_ce_nxt   = w_ce;
               w_cfg_odd_nxt  = w_par;
               w_cfg_two_nxt  = w_two;
               w_cnt_nxt      = 3'd0;
               w_stop_cnt_nxt = 1'b0;
               w_bps_en_nxt   = 1'b1;
               w_tx_out_nxt   = 1'b0;
               w_state_nxt    = ST_START;
            end
         end
         ST_START: begin
            w_tx_out_nxt = 1'b0;
            if (tx_bps_clk) begin
               w_cnt_nxt    = 3'd0;
               w_tx_out_nxt = r_shift[0];
               w_state_nxt  = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tx_bps_clk) begin
               w_shift_nxt = {r_shift[0], r_shift[7:1]};
               if (r_cnt == 3'd7) begin
                  w_stop_cnt_nxt = 1'b0;
                  if (r_cfg_ce) begin
                     w_tx_out_nxt = w_par_bit;
                     w_state_nxt  = ST_PARITY;
                  end else begin
                     w_tx_out_nxt = 1'b1;
                     w_state_nxt  = ST_STOP;
                  end
               end else begin
                  w_cnt_nxt    = r_cnt + 3'd1;
                  w_tx_out_nxt = r_shift[1];
               end
            end
         end
         ST_PARITY: begin
            if (tx_bps_clk) begin
               w_stop_cnt_nxt = 1'b0;
               w_tx_out_nxt   = 1'b1;
               w_state_nxt    = ST_STOP;
            end
         end
         ST_STOP: begin
            w_tx_out_nxt = 1'b1;
            if (tx_bps_clk) begin
               if (r_cfg_two && !r_stop_cnt) begin
                  w_stop_cnt_nxt = 1'b1;
               end else begin
                  w_bps_en_nxt = 1'b0;
                  w_ack_nxt    = 1'b1;
                  w_state_nxt  = ST_ACK;
               end
            end
         end
         ST_ACK: begin
            w_tx_out_nxt = 1'b1;
            w_bps_en_nxt = 1'b0;
            w_ack_nxt    = 1'b1;
            if (!w_req) begin
               w_ack_nxt   = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_tx_out_nxt = 1'b1;
            w_bps_en_nxt = 1'b0;
            w_ack_nxt    = 1'b0;
            w_state_nxt  = ST_IDLE;
         end
      endcase
   end

   assign tx_out    = r_tx_out;
   assign tx_bps_en = r_bps_en;
   assign tx_ack    = r_ack;
   assign tx_busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire
